// File: rtl/clock_display_scan.sv
// Scans a tear-free snapshot of the mm:ss BCD digits onto a 4-digit common-anode
// seven-segment display, with a blinking colon and optional leading-zero blanking.
module clock_display_scan #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rightSec,
    input  logic [2:0] leftSec,
    input  logic [3:0] rightMin,
    input  logic [2:0] leftMin,
    input  logic       load,
    input  logic       blank_lead,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FC_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        DIG_RSEC = 2'd0,
        DIG_LSEC = 2'd1,
        DIG_RMIN = 2'd2,
        DIG_LMIN = 2'd3
    } digit_t;

    logic [DIV_W-1:0] div;
    logic [FC_W-1:0]  fc;
    digit_t           index;
    digit_t           index_next;
    logic             phase;
    logic             pending;
    logic [13:0]      sh;
    logic [13:0]      sh_next;
    logic             div_wrap;
    logic             frame_wrap;
    logic             capture;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    // Codes above max_code (tens digits stop at 5) light nothing.
    function automatic logic [6:0] decode(input logic [3:0] code, input logic [3:0] max_code);
        if (code > max_code) return 7'h7F;
        case (code)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // The output register is loaded with the digit being entered, so a capture on
    // the wrap edge must feed the new shadow straight into digit 0's decode.
    always_comb begin
        div_wrap   = (div == DIV_LAST);
        frame_wrap = div_wrap && (index == DIG_LMIN);
        capture    = frame_wrap && (pending || load);
        sh_next    = capture ? {leftMin, rightMin, leftSec, rightSec} : sh;
        index_next = DIG_RSEC;
        an_next    = 4'b1111;
        seg_next   = 7'h7F;
        dp_next    = 1'b1;
        unique case (index)
            DIG_RSEC: index_next = DIG_LSEC;
            DIG_LSEC: index_next = DIG_RMIN;
            DIG_RMIN: index_next = DIG_LMIN;
            DIG_LMIN: index_next = DIG_RSEC;
        endcase
        unique case (index_next)
            DIG_RSEC: begin
                an_next  = 4'b1110;
                seg_next = decode(sh_next[3:0], 4'd9);
            end
            DIG_LSEC: begin
                an_next  = 4'b1101;
                seg_next = decode({1'b0, sh_next[6:4]}, 4'd5);
            end
            DIG_RMIN: begin
                an_next  = 4'b1011;
                seg_next = decode(sh_next[10:7], 4'd9);
                dp_next  = ~phase;
            end
            DIG_LMIN: begin
                if (!(blank_lead && sh_next[13:11] == 3'd0)) begin
                    an_next  = 4'b0111;
                    seg_next = decode({1'b0, sh_next[13:11]}, 4'd5);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div        <= '0;
            index      <= DIG_RSEC;
            fc         <= '0;
            phase      <= 1'b0;
            pending    <= 1'b0;
            sh         <= '0;
            an         <= 4'b1110;
            seg        <= 7'h40;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_wrap;
            sh         <= sh_next;
            if (frame_wrap) begin
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
            if (div_wrap) begin
                div   <= '0;
                index <= index_next;
                an    <= an_next;
                seg   <= seg_next;
                dp    <= dp_next;
            end else begin
                div <= div + 1'b1;
            end
            if (frame_wrap) begin
                if (fc == FC_LAST) begin
                    fc    <= '0;
                    phase <= ~phase;
                end else begin
                    fc <= fc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: a frame/time-arithmetic model checked every cycle,
// plus literal expectations at known points of a directed sequence, then random traffic.
module tb_clock_display_scan;

    localparam int SD = 4;
    localparam int BD = 2;

    logic       clk;
    logic       rst;
    logic [3:0] rightSec;
    logic [2:0] leftSec;
    logic [3:0] rightMin;
    logic [2:0] leftMin;
    logic       load;
    logic       blank_lead;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    clock_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rightSec   (rightSec),
        .leftSec    (leftSec),
        .rightMin   (rightMin),
        .leftMin    (leftMin),
        .load       (load),
        .blank_lead (blank_lead),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    int checks   = 0;
    int failures = 0;
    int dir_mode = 1;
    bit cmp_on   = 0;

    // Model state: edges since reset release and the digits currently on show.
    int         m_n       = 0;
    bit         m_pending = 0;
    int         m_dig [4] = '{0, 0, 0, 0};
    logic [3:0] m_an      = 4'b1110;
    logic [6:0] m_seg     = 7'h40;
    logic       m_dp      = 1'b1;
    logic       m_fd      = 1'b0;
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] segOf(input int v, input int maxv);
        if (v > maxv) return 7'h7F;
        return seg_tab[v];
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int idx;
        int frame;
        int ph;
        bit wrap;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_n       = 0;
                m_pending = 0;
                m_dig     = '{0, 0, 0, 0};
                m_an      = 4'b1110;
                m_seg     = 7'h40;
                m_dp      = 1'b1;
                m_fd      = 1'b0;
            end else begin
                m_n  = m_n + 1;
                wrap = (m_n % (4 * SD) == 0);
                if (wrap) begin
                    if (m_pending || load)
                        m_dig = '{int'(rightSec), int'(leftSec), int'(rightMin), int'(leftMin)};
                    m_pending = 0;
                end else if (load) begin
                    m_pending = 1;
                end
                m_fd = wrap;
                if (m_n % SD == 0) begin
                    idx   = (m_n / SD) % 4;
                    frame = m_n / (4 * SD);
                    ph    = (frame / BD) % 2;
                    m_an  = ~(4'b0001 << idx);
                    m_seg = segOf(m_dig[idx], (idx % 2 == 1) ? 5 : 9);
                    m_dp  = !(idx == 2 && ph == 1);
                    if (idx == 3 && blank_lead && m_dig[3] == 0) begin
                        m_an  = 4'b1111;
                        m_seg = 7'h7F;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %02h, want %02h (t=%0t n=%0d)", name, act, exp, $time, m_n);
        end
    endtask

    // Single compare process: model every cycle, literals at fixed points.
    initial begin
        forever begin
            @(negedge clk or negedge rst);
            #1;
            if (cmp_on) begin
                checkOutput("an", {4'b0, an}, {4'b0, m_an});
                checkOutput("seg", {1'b0, seg}, {1'b0, m_seg});
                checkOutput("dp", {7'b0, dp}, {7'b0, m_dp});
                checkOutput("frame_done", {7'b0, frame_done}, {7'b0, m_fd});
                if (!rst) begin
                    checkOutput("rst_an", {4'b0, an}, 8'h0E);
                    checkOutput("rst_seg", {1'b0, seg}, 8'h40);
                    checkOutput("rst_dp", {7'b0, dp}, 8'h01);
                    checkOutput("rst_fd", {7'b0, frame_done}, 8'h00);
                end else if (dir_mode == 1) begin
                    case (m_n)
                        2:  begin checkOutput("f0_an0", {4'b0, an}, 8'h0E); checkOutput("f0_seg0", {1'b0, seg}, 8'h40); end
                        6:  begin checkOutput("f0_an1", {4'b0, an}, 8'h0D); checkOutput("f0_seg1", {1'b0, seg}, 8'h40); end
                        10: begin checkOutput("f0_an2", {4'b0, an}, 8'h0B); checkOutput("f0_dp2", {7'b0, dp}, 8'h01); end
                        14: begin checkOutput("f0_an3", {4'b0, an}, 8'h07); checkOutput("f0_seg3", {1'b0, seg}, 8'h40); end
                        16: begin checkOutput("fd_pulse", {7'b0, frame_done}, 8'h01); checkOutput("f1_seg0", {1'b0, seg}, 8'h19); end
                        17: checkOutput("fd_clear", {7'b0, frame_done}, 8'h00);
                        22: begin checkOutput("f1_an1", {4'b0, an}, 8'h0D); checkOutput("f1_seg1", {1'b0, seg}, 8'h30); end
                        26: begin checkOutput("f1_seg2", {1'b0, seg}, 8'h24); checkOutput("f1_dp2", {7'b0, dp}, 8'h01); end
                        30: begin checkOutput("f1_an3", {4'b0, an}, 8'h07); checkOutput("f1_seg3", {1'b0, seg}, 8'h79); end
                        34: checkOutput("noload_seg0", {1'b0, seg}, 8'h19);
                        38: checkOutput("f2_dp1", {7'b0, dp}, 8'h01);
                        42: checkOutput("f2_dp2", {7'b0, dp}, 8'h00);
                        48: checkOutput("wrapload_seg0", {1'b0, seg}, 8'h78);
                        52: checkOutput("f3_seg1", {1'b0, seg}, 8'h12);
                        56: begin checkOutput("f3_seg2", {1'b0, seg}, 8'h10); checkOutput("f3_dp2", {7'b0, dp}, 8'h00); end
                        60: checkOutput("f3_seg3", {1'b0, seg}, 8'h12);
                        74: checkOutput("f4_dp2", {7'b0, dp}, 8'h01);
                        88: checkOutput("f5_seg2", {1'b0, seg}, 8'h12);
                        92: begin checkOutput("blank_an", {4'b0, an}, 8'h0F); checkOutput("blank_seg", {1'b0, seg}, 8'h7F); end
                        108: begin checkOutput("noblank_an", {4'b0, an}, 8'h07); checkOutput("noblank_seg", {1'b0, seg}, 8'h40); end
                        120: begin
                            checkOutput("badcode_an", {4'b0, an}, 8'h0B);
                            checkOutput("badcode_seg", {1'b0, seg}, 8'h7F);
                            checkOutput("f7_dp2", {7'b0, dp}, 8'h00);
                        end
                        default: ;
                    endcase
                end else if (dir_mode == 2) begin
                    case (m_n)
                        2:  checkOutput("rr_an0", {4'b0, an}, 8'h0E);
                        4:  checkOutput("rr_an1", {4'b0, an}, 8'h0D);
                        18: checkOutput("rr_discard_seg0", {1'b0, seg}, 8'h40);
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] rs, input logic [2:0] ls, input logic [3:0] rm,
                                 input logic [2:0] lm, input logic ld, input logic bl);
        rightSec   = rs;
        leftSec    = ls;
        rightMin   = rm;
        leftMin    = lm;
        load       = ld;
        blank_lead = bl;
    endtask

    task automatic toN(input int k);
        while (m_n < k) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(4'd0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 cmp_on = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        toN(3);   applyStimulus(4'd4, 3'd3, 4'd2, 3'd1, 1'b1, 1'b0);
        toN(4);   load = 1'b0;
        toN(18);  applyStimulus(4'd9, 3'd5, 4'd9, 3'd5, 1'b0, 1'b0);
        toN(47);  applyStimulus(4'd7, 3'd5, 4'd9, 3'd5, 1'b1, 1'b0);
        toN(48);  load = 1'b0;
        toN(64);  applyStimulus(4'd7, 3'd5, 4'd5, 3'd0, 1'b1, 1'b1);
        toN(65);  load = 1'b0;
        toN(95);  blank_lead = 1'b0;
        toN(110); applyStimulus(4'd7, 3'd5, 4'hA, 3'd0, 1'b1, 1'b0);
        toN(111); load = 1'b0;
        toN(122); load = 1'b1;
        toN(123); load = 1'b0;
        #2 rst = 1'b0;
        dir_mode = 2;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        toN(5);   applyStimulus(4'd3, 3'd2, 4'd8, 3'd4, 1'b0, 1'b0);
        toN(20);
        dir_mode = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            applyStimulus(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
            if (i == 400) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
